// File: rtl/decompress_core_flag_bgr_same_pkg.sv
// Shared definitions for the flag-data decompressor: field widths, FSM states
// and the prefix-code table (stream-order bits stored LSB first) used by the compressor too.
package decompress_core_flag_bgr_same_pkg;

    localparam int RECORD_W    = 77;
    localparam int POS_W       = 6;
    localparam int FLAG_W      = 3;
    localparam int CNT_W       = 3;
    localparam int MAX_ENTRIES = 7;
    localparam int NUM_CODES   = 7;
    localparam int CODE_W      = 5;
    localparam int LEN_W       = 3;
    localparam int PTR_W       = 7;
    localparam int PTR_MAX     = 127;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_ENTRY,
        ST_DONE
    } state_t;

    function automatic logic [CODE_W-1:0] code_value(input logic [FLAG_W-1:0] flag);
        case (flag)
            3'd0:    code_value = 5'b00001;
            3'd1:    code_value = 5'b00000;
            3'd2:    code_value = 5'b00010;
            3'd3:    code_value = 5'b00011;
            3'd4:    code_value = 5'b00111;
            3'd5:    code_value = 5'b01111;
            3'd6:    code_value = 5'b11111;
            default: code_value = 5'b00000;
        endcase
    endfunction

    function automatic logic [LEN_W-1:0] code_len(input logic [FLAG_W-1:0] flag);
        case (flag)
            3'd0, 3'd1, 3'd2: code_len = 3'd2;
            3'd3:             code_len = 3'd3;
            3'd4:             code_len = 3'd4;
            3'd5, 3'd6:       code_len = 3'd5;
            default:          code_len = 3'd0;
        endcase
    endfunction

    function automatic logic [CODE_W-1:0] code_mask(input logic [LEN_W-1:0] len);
        case (len)
            3'd2:    code_mask = 5'b00011;
            3'd3:    code_mask = 5'b00111;
            3'd4:    code_mask = 5'b01111;
            3'd5:    code_mask = 5'b11111;
            default: code_mask = 5'b00000;
        endcase
    endfunction

endpackage

// File: rtl/decompress_core_flag_bgr_same_flag_code_decode.sv
// Combinational prefix-code decoder: 5-bit window (bit 0 = first stream bit)
// to flag value and code length, matched against the shared code table.
module decompress_core_flag_bgr_same_flag_code_decode
    import decompress_core_flag_bgr_same_pkg::*;
(
    input  logic [CODE_W-1:0] window_i,
    output logic [FLAG_W-1:0] flag_o,
    output logic [LEN_W-1:0]  len_o
);

    // The code is prefix-free and complete, so exactly one table entry matches.
    always_comb begin
        flag_o = '0;
        len_o  = '0;
        for (int f = 0; f < NUM_CODES; f++) begin
            if ((window_i & code_mask(code_len(FLAG_W'(f)))) == code_value(FLAG_W'(f))) begin
                flag_o = FLAG_W'(f);
                len_o  = code_len(FLAG_W'(f));
            end
        end
    end

endmodule

// File: rtl/decompress_core_flag_bgr_same.sv
// Flag-record decompressor: walks one entry per clock rebuilding positions and flags.
// Optional macro FLAG_DECOMP_CHECK_EN builds the length/overrun check driving o_err.
module decompress_core_flag_bgr_same
    import decompress_core_flag_bgr_same_pkg::*;
#(
    parameter logic [3:0] TILE_SIZE = 4'd8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_valid,
    output logic                             i_ready,
    input  logic [RECORD_W-1:0]              flag_data_compressed,
    input  logic [3:0]                       flag_data_compressed_bytesize,
    output logic [CNT_W-1:0]                 diff_num,
    output logic [POS_W*MAX_ENTRIES-1:0]     diff_position,
    output logic [FLAG_W*MAX_ENTRIES-1:0]    diff_flag,
    output logic                             o_valid,
    output logic                             o_err
);

    state_t                          state_q, state_d;
    logic [RECORD_W-1:0]             word_q, word_d;
    logic [CNT_W-1:0]                num_q, num_d;
    logic [CNT_W-1:0]                idx_q, idx_d;
    logic [PTR_W-1:0]                ptr_q, ptr_d;
    logic [POS_W*MAX_ENTRIES-1:0]    pos_q, pos_d;
    logic [FLAG_W*MAX_ENTRIES-1:0]   flag_q, flag_d;

    logic [RECORD_W+63:0]            word_ext;
    logic [10:0]                     entry_bits;
    logic [POS_W-1:0]                entry_pos;
    logic [CODE_W-1:0]               entry_win;
    logic [FLAG_W-1:0]               dec_flag;
    logic [LEN_W-1:0]                dec_len;
    logic [PTR_W:0]                  ptr_sum;
    logic                            err_flag;
    logic                            unused_tile;

    assign unused_tile = ^TILE_SIZE;

    // Zero-extending past the record makes reads beyond bit 76 return 0.
    assign word_ext   = {64'b0, word_q};
    assign entry_bits = 11'(word_ext >> ptr_q);
    assign entry_pos  = entry_bits[POS_W-1:0];
    assign entry_win  = entry_bits[POS_W+CODE_W-1:POS_W];
    assign ptr_sum    = {1'b0, ptr_q} + 8'(POS_W) + 8'(dec_len);

    decompress_core_flag_bgr_same_flag_code_decode u_flag_code_decode (
        .window_i (entry_win),
        .flag_o   (dec_flag),
        .len_o    (dec_len)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (i_valid) state_d = ST_HDR;
            ST_HDR:   state_d = (word_q[CNT_W-1:0] == '0) ? ST_DONE : ST_ENTRY;
            ST_ENTRY: if (idx_q == num_q - 3'd1) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Gating with rst_n keeps i_ready low while reset is held.
    always_comb begin
        i_ready = rst_n && (state_q == ST_IDLE);
        o_valid = (state_q == ST_DONE);
        o_err   = (state_q == ST_DONE) && err_flag;
    end

    always_comb begin
        word_d = word_q;
        num_d  = num_q;
        idx_d  = idx_q;
        ptr_d  = ptr_q;
        pos_d  = pos_q;
        flag_d = flag_q;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    word_d = flag_data_compressed;
                    num_d  = '0;
                    pos_d  = '0;
                    flag_d = '0;
                end
            end
            ST_HDR: begin
                num_d = word_q[CNT_W-1:0];
                ptr_d = PTR_W'(CNT_W);
                idx_d = '0;
            end
            ST_ENTRY: begin
                for (int k = 0; k < MAX_ENTRIES; k++) begin
                    if (idx_q == CNT_W'(k)) begin
                        pos_d[k*POS_W +: POS_W]   = entry_pos;
                        flag_d[k*FLAG_W +: FLAG_W] = dec_flag;
                    end
                end
                ptr_d = (ptr_sum > 8'(PTR_MAX)) ? PTR_W'(PTR_MAX) : ptr_sum[PTR_W-1:0];
                idx_d = idx_q + 3'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            num_q  <= '0;
            idx_q  <= '0;
            ptr_q  <= '0;
            pos_q  <= '0;
            flag_q <= '0;
        end else begin
            word_q <= word_d;
            num_q  <= num_d;
            idx_q  <= idx_d;
            ptr_q  <= ptr_d;
            pos_q  <= pos_d;
            flag_q <= flag_d;
        end
    end

    assign diff_num      = num_q;
    assign diff_position = pos_q;
    assign diff_flag     = flag_q;

`ifdef FLAG_DECOMP_CHECK_EN
    logic [3:0] bytes_q;
    logic       ovr_q;

    // An entry overruns when its last consumed bit lies at index 77 or above.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bytes_q <= '0;
            ovr_q   <= 1'b0;
        end else if (state_q == ST_IDLE && i_valid) begin
            bytes_q <= flag_data_compressed_bytesize;
            ovr_q   <= 1'b0;
        end else if (state_q == ST_ENTRY && ptr_sum > 8'(RECORD_W)) begin
            ovr_q   <= 1'b1;
        end
    end

    assign err_flag = ovr_q || ({1'b0, ptr_q} > {1'b0, bytes_q, 3'b000});
`else
    logic unused_bytes;
    assign unused_bytes = ^flag_data_compressed_bytesize;
    assign err_flag     = 1'b0;
`endif

endmodule

// File: tb/tb_decompress_core_flag_bgr_same.sv
// Directed self-checking bench for the flag-record decompressor; expected
// values come from hand-computed constants and a small local encoder.
module tb_decompress_core_flag_bgr_same;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid;
    logic        i_ready;
    logic [76:0] flag_data_compressed;
    logic [3:0]  flag_data_compressed_bytesize;
    logic [2:0]  diff_num;
    logic [41:0] diff_position;
    logic [20:0] diff_flag;
    logic        o_valid;
    logic        o_err;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    decompress_core_flag_bgr_same #(.TILE_SIZE(4'd8)) dut (
        .clk                           (clk),
        .rst_n                         (rst_n),
        .i_valid                       (i_valid),
        .i_ready                       (i_ready),
        .flag_data_compressed          (flag_data_compressed),
        .flag_data_compressed_bytesize (flag_data_compressed_bytesize),
        .diff_num                      (diff_num),
        .diff_position                 (diff_position),
        .diff_flag                     (diff_flag),
        .o_valid                       (o_valid),
        .o_err                         (o_err)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [76:0] word, input logic [3:0] bytes);
        @(negedge clk);
        i_valid                       = 1'b1;
        flag_data_compressed          = word;
        flag_data_compressed_bytesize = bytes;
        checkOutput("ready_at_accept", 64'(i_ready), 64'd1);
    endtask

    task automatic waitValid(output int cycles);
        bit found;
        found  = 1'b0;
        cycles = 0;
        for (int c = 1; c <= 20 && !found; c++) begin
            @(negedge clk);
            i_valid = 1'b0;
            if (o_valid === 1'b1) begin
                found  = 1'b1;
                cycles = c;
            end
        end
    endtask

    // Stream-order code bits, first bit in bit 0.
    function automatic logic [76:0] encodeRecord(input int n, input int pos[7], input int flg[7]);
        int codeLen[7]  = '{2, 2, 2, 3, 4, 5, 5};
        int codeBits[7] = '{1, 0, 2, 3, 7, 15, 31};
        logic [76:0] w;
        int p;
        w = '0;
        w[2:0] = 3'(n);
        p = 3;
        for (int e = 0; e < n; e++) begin
            for (int b = 0; b < 6; b++) w[p + b] = 1'((pos[e] >> b) & 1);
            p += 6;
            for (int b = 0; b < codeLen[flg[e]]; b++) w[p + b] = 1'((codeBits[flg[e]] >> b) & 1);
            p += codeLen[flg[e]];
        end
        return w;
    endfunction

    initial begin
        int          lat;
        int          seenValid;
        int          pos7[7];
        int          flg7[7];
        logic [76:0] rec7;
        logic [41:0] expPos7;
        logic        expErr;

`ifdef FLAG_DECOMP_CHECK_EN
        expErr = 1'b1;
`else
        expErr = 1'b0;
`endif
        pos7 = '{10, 20, 30, 40, 50, 60, 63};
        flg7 = '{0, 1, 2, 3, 4, 5, 6};
        rec7 = encodeRecord(7, pos7, flg7);
        expPos7 = '0;
        for (int k = 0; k < 7; k++) expPos7[k*6 +: 6] = 6'(pos7[k]);

        rst_n                         = 1'b0;
        i_valid                       = 1'b0;
        flag_data_compressed          = '0;
        flag_data_compressed_bytesize = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_ready", 64'(i_ready), 64'd0);
        checkOutput("rst_valid", 64'(o_valid), 64'd0);
        checkOutput("rst_num", 64'(diff_num), 64'd0);
        checkOutput("rst_pos", 64'(diff_position), 64'd0);
        checkOutput("rst_flag", 64'(diff_flag), 64'd0);
        checkOutput("rst_err", 64'(o_err), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_rst", 64'(i_ready), 64'd1);

        $display("[TB] N=0 record");
        applyStimulus(77'h0, 4'd1);
        waitValid(lat);
        checkOutput("n0_latency", 64'(lat), 64'd2);
        checkOutput("n0_num", 64'(diff_num), 64'd0);
        checkOutput("n0_pos", 64'(diff_position), 64'd0);
        checkOutput("n0_flag", 64'(diff_flag), 64'd0);
        checkOutput("n0_err", 64'(o_err), 64'd0);
        @(negedge clk);
        checkOutput("n0_pulse_end", 64'(o_valid), 64'd0);
        checkOutput("n0_ready_back", 64'(i_ready), 64'd1);

        $display("[TB] single entry pos 5 flag 1");
        applyStimulus(77'h29, 4'd2);
        waitValid(lat);
        checkOutput("e1_latency", 64'(lat), 64'd3);
        checkOutput("e1_num", 64'(diff_num), 64'd1);
        checkOutput("e1_pos", 64'(diff_position), 64'd5);
        checkOutput("e1_flag", 64'(diff_flag), 64'd1);
        checkOutput("e1_err", 64'(o_err), 64'd0);

        $display("[TB] single entry pos 63 flag 6");
        applyStimulus(77'h3FF9, 4'd2);
        waitValid(lat);
        checkOutput("e6_latency", 64'(lat), 64'd3);
        checkOutput("e6_pos", 64'(diff_position), 64'd63);
        checkOutput("e6_flag", 64'(diff_flag), 64'd6);
        checkOutput("e6_err", 64'(o_err), 64'd0);

        applyStimulus(77'h3FF9, 4'd1);
        waitValid(lat);
        checkOutput("short_latency", 64'(lat), 64'd3);
        checkOutput("short_err", 64'(o_err), 64'(expErr));

        $display("[TB] seven entries, flags 0..6");
        applyStimulus(rec7, 4'd9);
        waitValid(lat);
        checkOutput("e7_latency", 64'(lat), 64'd9);
        checkOutput("e7_num", 64'(diff_num), 64'd7);
        checkOutput("e7_pos", 64'(diff_position), 64'(expPos7));
        checkOutput("e7_flag", 64'(diff_flag), 64'(21'o6543210));
        checkOutput("e7_err", 64'(o_err), 64'd0);
        repeat (3) @(negedge clk);
        checkOutput("e7_hold_pos", 64'(diff_position), 64'(expPos7));
        checkOutput("e7_hold_flag", 64'(diff_flag), 64'(21'o6543210));

        $display("[TB] back-to-back with i_valid held high");
        applyStimulus(77'h29, 4'd2);
        @(negedge clk);
        checkOutput("b2b_ready_t1", 64'(i_ready), 64'd0);
        flag_data_compressed = 77'h3FF9;
        @(negedge clk);
        checkOutput("b2b_ready_t2", 64'(i_ready), 64'd0);
        checkOutput("b2b_valid_t2", 64'(o_valid), 64'd0);
        @(negedge clk);
        checkOutput("b2b_valid_t3", 64'(o_valid), 64'd1);
        checkOutput("b2b_pos_a", 64'(diff_position), 64'd5);
        checkOutput("b2b_flag_a", 64'(diff_flag), 64'd1);
        @(negedge clk);
        checkOutput("b2b_ready_t4", 64'(i_ready), 64'd1);
        checkOutput("b2b_valid_t4", 64'(o_valid), 64'd0);
        @(negedge clk);
        i_valid = 1'b0;
        checkOutput("b2b_ready_t5", 64'(i_ready), 64'd0);
        checkOutput("b2b_cleared_pos", 64'(diff_position), 64'd0);
        checkOutput("b2b_cleared_num", 64'(diff_num), 64'd0);
        @(negedge clk);
        checkOutput("b2b_valid_t6", 64'(o_valid), 64'd0);
        @(negedge clk);
        checkOutput("b2b_valid_t7", 64'(o_valid), 64'd1);
        checkOutput("b2b_pos_b", 64'(diff_position), 64'd63);
        checkOutput("b2b_flag_b", 64'(diff_flag), 64'd6);

        $display("[TB] reset during ENTRY");
        applyStimulus(rec7, 4'd9);
        @(negedge clk);
        i_valid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("abort_num_loaded", 64'(diff_num), 64'd7);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_ready", 64'(i_ready), 64'd0);
        checkOutput("abort_num", 64'(diff_num), 64'd0);
        checkOutput("abort_pos", 64'(diff_position), 64'd0);
        checkOutput("abort_flag", 64'(diff_flag), 64'd0);
        checkOutput("abort_valid", 64'(o_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seenValid = 0;
        @(negedge clk);
        checkOutput("abort_ready_back", 64'(i_ready), 64'd1);
        for (int c = 0; c < 12; c++) begin
            if (o_valid !== 1'b0) seenValid++;
            @(negedge clk);
        end
        checkOutput("abort_no_valid", 64'(seenValid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
